// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control types for the stall/flush controller.
//   stall_state_t : controller state (RUN, DIV_WAIT, MEM_WAIT)
//   bank_ctrl_t   : per-register-bank control bundle {stop, flush, en}
//   DIV_CYCLES_DEFAULT : latency of the EX-stage divider, shared with the divider
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } stall_state_t;

  typedef struct packed {
    logic stop;
    logic flush;
    logic en;
  } bank_ctrl_t;

  localparam int unsigned DIV_CYCLES_DEFAULT = 33;

  localparam bank_ctrl_t BANK_EN    = 3'b001;
  localparam bank_ctrl_t BANK_STOP  = 3'b100;
  localparam bank_ctrl_t BANK_FLUSH = 3'b010;
  localparam bank_ctrl_t BANK_IDLE  = 3'b000;

endpackage

// File: rtl/pipe_stall_ctrl_perf_counter.sv
// Stall-cycle performance counter: PERF_W-bit counter that increments on en
// and wraps modulo 2^PERF_W.
//   clk    : clock
//   resetn : synchronous active-low clear
//   en     : count this cycle
//   count  : current count
module stall_perf_counter #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (en) begin
      count <= count + PERF_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Inputs : clk, resetn (sync, active-low), load_use, div_start, mem_req,
//          mem_ready, branch_flush, exc_valid.
// Outputs: pc_stop; {fd,de,em,mw}_{stop,flush,en} bank controls;
//          div_busy / div_done / div_cancel divider status;
//          stall_cycles = number of cycles with pc_stop=1.
// Fixed priority: exception > mem stall > div stall > load-use > branch > none.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_use,
  input  logic              div_start,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              branch_flush,
  input  logic              exc_valid,
  output logic              pc_stop,
  output logic              fd_stop,
  output logic              de_stop,
  output logic              em_stop,
  output logic              mw_stop,
  output logic              fd_flush,
  output logic              de_flush,
  output logic              em_flush,
  output logic              mw_flush,
  output logic              fd_en,
  output logic              de_en,
  output logic              em_en,
  output logic              mw_en,
  output logic              div_busy,
  output logic              div_done,
  output logic              div_cancel,
  output logic [PERF_W-1:0] stall_cycles
);

  stall_state_t     state;
  logic [CNT_W-1:0] cnt;

  logic       mem_stall;
  logic       div_stall;
  logic       pc_hold;
  bank_ctrl_t fd, de, em, mw;

  always_comb begin
    mem_stall = mem_req & ~mem_ready;
    div_stall = ((state == DIV_WAIT) && (cnt != '0)) ||
                ((state == RUN) && div_start);

    pc_hold    = 1'b0;
    fd         = BANK_EN;
    de         = BANK_EN;
    em         = BANK_EN;
    mw         = BANK_EN;
    div_done   = 1'b0;
    div_cancel = 1'b0;

    if (!resetn) begin
      fd = BANK_FLUSH;
      de = BANK_FLUSH;
      em = BANK_FLUSH;
      mw = BANK_FLUSH;
    end else if (exc_valid) begin
      fd         = BANK_FLUSH;
      de         = BANK_FLUSH;
      em         = BANK_FLUSH;
      mw         = BANK_FLUSH;
      div_cancel = (state == DIV_WAIT);
    end else if (mem_stall) begin
      pc_hold = 1'b1;
      fd      = BANK_STOP;
      de      = BANK_STOP;
      em      = BANK_STOP;
      mw      = BANK_FLUSH;
    end else if (div_stall) begin
      pc_hold = 1'b1;
      fd      = BANK_STOP;
      de      = BANK_STOP;
      em      = BANK_FLUSH;
    end else if (load_use) begin
      pc_hold = 1'b1;
      fd      = BANK_STOP;
      de      = BANK_FLUSH;
    end else if (branch_flush) begin
      fd = BANK_FLUSH;
      de = BANK_FLUSH;
    end

    // Result is consumed on the first cycle the countdown is exhausted and
    // EX is free to advance (not held by a mem stall, not killed).
    if (resetn && !exc_valid && !mem_stall && (state == DIV_WAIT) && (cnt == '0)) begin
      div_done = 1'b1;
    end
  end

  // A mem stall in DIV_WAIT does not leave DIV_WAIT; only the countdown keeps
  // running, so the divide resumes naturally when the stall clears.
  // A div_start coinciding with a mem stall in RUN is not accepted: EX is held
  // and the divide is reissued once the stall clears.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
      cnt   <= '0;
    end else if (exc_valid) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state <= MEM_WAIT;
          end else if (div_start) begin
            state <= DIV_WAIT;
            cnt   <= CNT_W'(DIV_CYCLES - 1);
          end
        end
        DIV_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!mem_stall) begin
            state <= RUN;
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  stall_perf_counter #(
    .PERF_W(PERF_W)
  ) u_perf (
    .clk    (clk),
    .resetn (resetn),
    .en     (pc_hold),
    .count  (stall_cycles)
  );

  assign pc_stop  = pc_hold;
  assign fd_stop  = fd.stop;
  assign de_stop  = de.stop;
  assign em_stop  = em.stop;
  assign mw_stop  = mw.stop;
  assign fd_flush = fd.flush;
  assign de_flush = de.flush;
  assign em_flush = em.flush;
  assign mw_flush = mw.flush;
  assign fd_en    = fd.en;
  assign de_en    = de.en;
  assign em_en    = em.en;
  assign mw_en    = mw.en;
  assign div_busy = resetn && (state == DIV_WAIT);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (DIV_CYCLES=4, PERF_W=4):
// a directed vector table, a counter-wrap sequence and a randomized phase
// checked against a cycle-count based reference model.
module tb_pipe_stall_ctrl;
  localparam int unsigned DC = 4;
  localparam int unsigned PW = 4;

  logic clk = 1'b0;
  logic resetn, load_use, div_start, mem_req, mem_ready, branch_flush, exc_valid;
  logic pc_stop, fd_stop, de_stop, em_stop, mw_stop;
  logic fd_flush, de_flush, em_flush, mw_flush;
  logic fd_en, de_en, em_en, mw_en;
  logic div_busy, div_done, div_cancel;
  logic [PW-1:0] stall_cycles;
  logic [15:0] act;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .DIV_CYCLES(DC),
    .CNT_W(3),
    .PERF_W(PW)
  ) dut (
    .clk(clk), .resetn(resetn), .load_use(load_use), .div_start(div_start),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_flush(branch_flush),
    .exc_valid(exc_valid), .pc_stop(pc_stop),
    .fd_stop(fd_stop), .de_stop(de_stop), .em_stop(em_stop), .mw_stop(mw_stop),
    .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
    .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
    .div_busy(div_busy), .div_done(div_done), .div_cancel(div_cancel),
    .stall_cycles(stall_cycles)
  );

  assign act = {pc_stop, fd_stop, de_stop, em_stop, mw_stop,
                fd_flush, de_flush, em_flush, mw_flush,
                fd_en, de_en, em_en, mw_en, div_busy, div_done, div_cancel};

  // Which priority row should drive the controls.
  typedef enum int {R_RST, R_EXC, R_MEM, R_DIV, R_LU, R_BR, R_NONE} row_t;
  typedef struct {
    logic [6:0] in;     // {resetn, load_use, div_start, mem_req, mem_ready, branch_flush, exc_valid}
    row_t       row;
    logic [2:0] dv;     // {div_busy, div_done, div_cancel}
    int         stall;  // stall_cycles seen before this cycle's edge
  } vec_t;

  localparam logic [6:0] I_RST  = 7'b0000000;
  localparam logic [6:0] I_IDLE = 7'b1000000;
  localparam logic [6:0] I_LU   = 7'b1100000;
  localparam logic [6:0] I_DS   = 7'b1010000;
  localparam logic [6:0] I_MQ   = 7'b1001000;
  localparam logic [6:0] I_ZW   = 7'b1001100;
  localparam logic [6:0] I_BR   = 7'b1000010;
  localparam logic [6:0] I_EXAL = 7'b1101011;

  int checks = 0;
  int errors = 0;

  // Reference model: a divide is tracked by its start cycle, memory waiting
  // by whether the previous cycle ended in an unfinished access.
  bit m_div_on   = 1'b0;
  bit m_mem_pend = 1'b0;
  int m_t0       = 0;
  int m_cyc      = 0;
  int m_stall    = 0;

  vec_t tab[$];

  function automatic vec_t mk(logic [6:0] in, row_t r, logic [2:0] dv, int st);
    vec_t v;
    v.in = in; v.row = r; v.dv = dv; v.stall = st;
    return v;
  endfunction

  // Spell out the controls of a priority row: code 0=load, 1=hold, 2=bubble.
  function automatic logic [15:0] expand(row_t r, logic [2:0] dv);
    int code [4];
    logic pc;
    logic [3:0] s, f, e;
    pc = 1'b0;
    code = '{0, 0, 0, 0};
    case (r)
      R_RST, R_EXC: code = '{2, 2, 2, 2};
      R_MEM: begin pc = 1'b1; code = '{1, 1, 1, 2}; end
      R_DIV: begin pc = 1'b1; code = '{1, 1, 2, 0}; end
      R_LU:  begin pc = 1'b1; code = '{1, 2, 0, 0}; end
      R_BR:  code = '{2, 2, 0, 0};
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      s[3-i] = (code[i] == 1);
      f[3-i] = (code[i] == 2);
      e[3-i] = (code[i] == 0);
    end
    return {pc, s, f, e, dv};
  endfunction

  function automatic void model_eval(input logic [6:0] in, output row_t r, output logic [2:0] dv);
    bit ms, run;
    int el;
    ms  = in[3] && !in[2];
    run = !m_div_on && !m_mem_pend;
    el  = m_cyc - m_t0;
    dv  = 3'b000;
    if (!in[6]) begin
      r = R_RST;
    end else if (in[0]) begin
      r  = R_EXC;
      dv = {m_div_on, 1'b0, m_div_on};
    end else begin
      if (ms) r = R_MEM;
      else if ((m_div_on && el < int'(DC)) || (run && in[4])) r = R_DIV;
      else if (in[5]) r = R_LU;
      else if (in[1]) r = R_BR;
      else r = R_NONE;
      dv = {m_div_on, m_div_on && !ms && el >= int'(DC), 1'b0};
    end
  endfunction

  task automatic model_update(input logic [6:0] in, input bit pcs);
    bit ms;
    ms = in[3] && !in[2];
    if (!in[6]) begin
      m_div_on = 1'b0; m_mem_pend = 1'b0; m_stall = 0;
    end else begin
      if (pcs) m_stall = (m_stall + 1) % (1 << PW);
      if (in[0]) begin
        m_div_on = 1'b0; m_mem_pend = 1'b0;
      end else if (m_div_on) begin
        if (!ms && (m_cyc - m_t0) >= int'(DC)) m_div_on = 1'b0;
      end else if (m_mem_pend) begin
        m_mem_pend = ms;
      end else if (ms) begin
        m_mem_pend = 1'b1;
      end else if (in[4]) begin
        m_div_on = 1'b1; m_t0 = m_cyc;
      end
    end
    m_cyc++;
  endtask

  task automatic run_cycle(input logic [6:0] in, input bit use_tab, input row_t trow,
                           input logic [2:0] tdv, input int tst, input string nm);
    row_t r;
    logic [2:0] dv;
    logic [15:0] mexp, exp_v;
    int exp_s;
    @(negedge clk);
    {resetn, load_use, div_start, mem_req, mem_ready, branch_flush, exc_valid} = in;
    #1;
    model_eval(in, r, dv);
    mexp  = expand(r, dv);
    exp_v = use_tab ? expand(trow, tdv) : mexp;
    exp_s = use_tab ? tst : m_stall;
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s ctrl: got %h want %h (in=%b)", nm, act, exp_v, in);
    end
    checks++;
    if (stall_cycles !== PW'(exp_s)) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, stall_cycles, exp_s);
    end
    @(posedge clk);
    model_update(in, mexp[15]);
  endtask

  initial begin
    {resetn, load_use, div_start, mem_req, mem_ready, branch_flush, exc_valid} = I_RST;

    tab.push_back(mk(I_RST,  R_RST,  3'b000, 0));
    tab.push_back(mk(I_RST,  R_RST,  3'b000, 0));
    tab.push_back(mk(I_IDLE, R_NONE, 3'b000, 0));
    tab.push_back(mk(I_LU,   R_LU,   3'b000, 0));
    tab.push_back(mk(I_IDLE, R_NONE, 3'b000, 1));
    tab.push_back(mk(I_DS,   R_DIV,  3'b000, 1));   // divide t0
    tab.push_back(mk(I_IDLE, R_DIV,  3'b100, 2));
    tab.push_back(mk(I_DS,   R_DIV,  3'b100, 3));   // restart ignored
    tab.push_back(mk(I_IDLE, R_DIV,  3'b100, 4));
    tab.push_back(mk(I_IDLE, R_NONE, 3'b110, 5));   // done at t0+DIV_CYCLES
    tab.push_back(mk(I_IDLE, R_NONE, 3'b000, 5));
    tab.push_back(mk(I_DS,   R_DIV,  3'b000, 5));   // divide t0, mem wait t1..t5
    tab.push_back(mk(I_MQ,   R_MEM,  3'b100, 6));
    tab.push_back(mk(I_MQ,   R_MEM,  3'b100, 7));
    tab.push_back(mk(I_MQ,   R_MEM,  3'b100, 8));
    tab.push_back(mk(I_MQ,   R_MEM,  3'b100, 9));
    tab.push_back(mk(I_MQ,   R_MEM,  3'b100, 10));
    tab.push_back(mk(I_IDLE, R_NONE, 3'b110, 11));  // deferred done at t6
    tab.push_back(mk(I_IDLE, R_NONE, 3'b000, 11));
    tab.push_back(mk(I_DS,   R_DIV,  3'b000, 11));
    tab.push_back(mk(I_EXAL, R_EXC,  3'b101, 12));  // exception beats everything
    tab.push_back(mk(I_IDLE, R_NONE, 3'b000, 12));
    tab.push_back(mk(I_ZW,   R_NONE, 3'b000, 12));  // zero-wait access
    tab.push_back(mk(I_BR,   R_BR,   3'b000, 12));
    tab.push_back(mk(I_MQ,   R_MEM,  3'b000, 12));
    tab.push_back(mk(I_MQ,   R_MEM,  3'b000, 13));
    tab.push_back(mk(I_IDLE, R_NONE, 3'b000, 14));  // abort
    tab.push_back(mk(I_IDLE, R_NONE, 3'b000, 14));
    tab.push_back(mk(I_DS,   R_DIV,  3'b000, 14));
    tab.push_back(mk(I_IDLE, R_DIV,  3'b100, 15));
    tab.push_back(mk(I_RST,  R_RST,  3'b000, 0));   // counter wrapped 15->0
    tab.push_back(mk(I_IDLE, R_NONE, 3'b000, 0));   // no pulse after reset

    @(posedge clk);
    foreach (tab[i]) begin
      run_cycle(tab[i].in, 1'b1, tab[i].row, tab[i].dv, tab[i].stall, $sformatf("vec%0d", i));
    end

    // 17 continuous stall cycles on a 4-bit counter
    run_cycle(I_RST, 1'b0, R_NONE, 3'b000, 0, "wrap_rst");
    for (int i = 0; i < 17; i++) run_cycle(I_MQ, 1'b0, R_NONE, 3'b000, 0, "wrap_stall");
    run_cycle(I_IDLE, 1'b0, R_NONE, 3'b000, 0, "wrap_idle");
    #1;
    checks++;
    if (stall_cycles !== PW'(1)) begin
      errors++;
      $display("FAIL wrap_final stall_cycles: got %0d want 1", stall_cycles);
    end

    for (int i = 0; i < 600; i++) begin
      logic [6:0] in;
      in[6] = ($urandom_range(0, 39) != 0);
      in[5] = ($urandom_range(0, 4) == 0);
      in[4] = ($urandom_range(0, 5) == 0);
      in[3] = ($urandom_range(0, 2) == 0);
      in[2] = ($urandom_range(0, 1) == 0);
      in[1] = ($urandom_range(0, 7) == 0);
      in[0] = ($urandom_range(0, 19) == 0);
      run_cycle(in, 1'b0, R_NONE, 3'b000, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
